// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI write-address arbitration slice.
// Holds the AW mux state encoding and the index-width helpers.
package axi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } aw_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int idx_width(input int req_num);
    return (clog2(req_num) > 1) ? clog2(req_num) : 1;
  endfunction

endpackage

// File: rtl/axi_ord_fifo.sv
// Synchronous order FIFO recording granted master indices for the W-channel router.
// Full is derived from the registered occupancy, so a same-cycle pop never frees a slot early.
module axi_ord_fifo
  import axi_arb_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int          AW        = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE       = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/axi_aw_grant_mux.sv
// AW-channel grant mux: accepts the arbiter-granted master beat, registers it to the slave port
// and logs the master index for W steering. Define AXI_AW_MUX_ID_EXT_EN to prefix m_awid with it.
module axi_aw_grant_mux
  import axi_arb_pkg::*;
#(
  parameter  int REQ_NUM   = 8,
  parameter  int ADDR_W    = 32,
  parameter  int ID_W      = 4,
  parameter  int LEN_W     = 8,
  parameter  int ORD_DEPTH = 4,
  localparam int IDX_W     = idx_width(REQ_NUM)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [REQ_NUM-1:0]        s_awvalid,
  output logic [REQ_NUM-1:0]        s_awready,
  input  logic [REQ_NUM*ADDR_W-1:0] s_awaddr,
  input  logic [REQ_NUM*ID_W-1:0]   s_awid,
  input  logic [REQ_NUM*LEN_W-1:0]  s_awlen,
  output logic [REQ_NUM-1:0]        arb_req,
  input  logic [REQ_NUM-1:0]        arb_grant,
  output logic                      arb_en,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_W-1:0]         m_awaddr,
`ifdef AXI_AW_MUX_ID_EXT_EN
  output logic [ID_W+IDX_W-1:0]     m_awid,
`else
  output logic [ID_W-1:0]           m_awid,
`endif
  output logic [LEN_W-1:0]          m_awlen,
  output logic                      ord_vld,
  output logic [IDX_W-1:0]          ord_idx,
  input  logic                      ord_pop
);

  aw_state_e         state;
  aw_state_e         state_nxt;
  logic              can_load;
  logic              grant_hit;
  logic              accept;
  logic              ord_full;
  logic              ord_empty;
  logic [IDX_W-1:0]  g_idx;
  logic [ADDR_W-1:0] g_addr;
  logic [ID_W-1:0]   g_id;
  logic [LEN_W-1:0]  g_len;

  // One-hot to index encode plus payload select; OR-merging is safe because accept demands one-hot.
  always_comb begin
    g_idx  = '0;
    g_addr = '0;
    g_id   = '0;
    g_len  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (arb_grant[i]) begin
        g_idx  = g_idx | IDX_W'(i);
        g_addr = g_addr | s_awaddr[i*ADDR_W +: ADDR_W];
        g_id   = g_id | s_awid[i*ID_W +: ID_W];
        g_len  = g_len | s_awlen[i*LEN_W +: LEN_W];
      end
    end
  end

  assign can_load  = (state == IDLE) | ((state == SEND) & m_awready);
  assign grant_hit = $onehot(arb_grant) & (|(arb_grant & s_awvalid));
  assign accept    = can_load & ~ord_full & grant_hit;

  assign arb_req   = can_load ? s_awvalid : '0;
  assign s_awready = accept ? arb_grant : '0;
  assign arb_en    = accept;
  assign m_awvalid = (state == SEND);
  assign ord_vld   = ~ord_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (m_awready && !accept) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload only moves on accept, which keeps it stable while the slave stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_awaddr <= '0;
      m_awid   <= '0;
      m_awlen  <= '0;
    end else if (accept) begin
      m_awaddr <= g_addr;
`ifdef AXI_AW_MUX_ID_EXT_EN
      m_awid   <= {g_idx, g_id};
`else
      m_awid   <= g_id;
`endif
      m_awlen  <= g_len;
    end
  end

  axi_ord_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ORD_DEPTH)
  ) u_ord_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data (g_idx),
    .pop       (ord_pop),
    .head      (ord_idx),
    .full      (ord_full),
    .empty     (ord_empty)
  );

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rstn) $onehot0(arb_grant));

endmodule

// File: tb/tb_axi_aw_grant_mux.sv
// Self-checking bench for axi_aw_grant_mux: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_aw_grant_mux;

  localparam int REQ_NUM   = 8;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;
  localparam int LEN_W     = 8;
  localparam int ORD_DEPTH = 4;
  localparam int IDX_W     = 3;
`ifdef AXI_AW_MUX_ID_EXT_EN
  localparam int MID_W = ID_W + IDX_W;
`else
  localparam int MID_W = ID_W;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [REQ_NUM-1:0]        valid;
  logic [REQ_NUM-1:0]        grant;
  logic                      m_awready;
  logic                      ord_pop;
  logic [ADDR_W-1:0]         addr_t [REQ_NUM];
  logic [ID_W-1:0]           id_t   [REQ_NUM];
  logic [LEN_W-1:0]          len_t  [REQ_NUM];
  logic [REQ_NUM*ADDR_W-1:0] s_awaddr;
  logic [REQ_NUM*ID_W-1:0]   s_awid;
  logic [REQ_NUM*LEN_W-1:0]  s_awlen;

  logic [REQ_NUM-1:0] s_awready;
  logic [REQ_NUM-1:0] arb_req;
  logic               arb_en;
  logic               m_awvalid;
  logic [ADDR_W-1:0]  m_awaddr;
  logic [MID_W-1:0]   m_awid;
  logic [LEN_W-1:0]   m_awlen;
  logic               ord_vld;
  logic [IDX_W-1:0]   ord_idx;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: one registered beat slot and a queue of logged indices.
  bit               mv      = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [MID_W-1:0]  e_id   = '0;
  logic [LEN_W-1:0]  e_len  = '0;
  int               ord_q[$];

  always_comb begin
    s_awaddr = '0;
    s_awid   = '0;
    s_awlen  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      s_awaddr[i*ADDR_W +: ADDR_W] = addr_t[i];
      s_awid[i*ID_W +: ID_W]       = id_t[i];
      s_awlen[i*LEN_W +: LEN_W]    = len_t[i];
    end
  end

  axi_aw_grant_mux #(
    .REQ_NUM   (REQ_NUM),
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W),
    .LEN_W     (LEN_W),
    .ORD_DEPTH (ORD_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_awvalid (valid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_awid    (s_awid),
    .s_awlen   (s_awlen),
    .arb_req   (arb_req),
    .arb_grant (grant),
    .arb_en    (arb_en),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_awid    (m_awid),
    .m_awlen   (m_awlen),
    .ord_vld   (ord_vld),
    .ord_idx   (ord_idx),
    .ord_pop   (ord_pop)
  );

  function automatic int grant_index(input logic [REQ_NUM-1:0] gv);
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gv[i]) return i;
    end
    return 0;
  endfunction

  function automatic bit model_accept();
    bit slot_free;
    bit legit;
    slot_free = !mv || (m_awready == 1'b1);
    legit     = $onehot(grant) && ((grant & valid) != '0);
    return slot_free && (ord_q.size() < ORD_DEPTH) && legit;
  endfunction

  function automatic logic [MID_W-1:0] model_id(input int g);
`ifdef AXI_AW_MUX_ID_EXT_EN
    return {IDX_W'(g), id_t[g]};
`else
    return id_t[g];
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit slot_free;
    bit acc;
    slot_free = !mv || (m_awready == 1'b1);
    acc       = model_accept();
    chk("arb_req",   64'(arb_req),   64'(slot_free ? valid : '0));
    chk("s_awready", 64'(s_awready), 64'(acc ? grant : '0));
    chk("arb_en",    64'(arb_en),    64'(acc));
    chk("m_awvalid", 64'(m_awvalid), 64'(mv));
    chk("m_awaddr",  64'(m_awaddr),  64'(e_addr));
    chk("m_awid",    64'(m_awid),    64'(e_id));
    chk("m_awlen",   64'(m_awlen),   64'(e_len));
    chk("ord_vld",   64'(ord_vld),   64'(ord_q.size() != 0));
    chk("ord_idx",   64'(ord_idx),   64'((ord_q.size() != 0) ? ord_q[0] : 0));
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) checkOutput();
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mv     = 1'b0;
      e_addr = '0;
      e_id   = '0;
      e_len  = '0;
      ord_q.delete();
    end else begin
      bit acc;
      int g;
      acc = model_accept();
      g   = grant_index(grant);
      if (ord_pop && ord_q.size() != 0) void'(ord_q.pop_front());
      if (acc) begin
        ord_q.push_back(g);
        mv     = 1'b1;
        e_addr = addr_t[g];
        e_id   = model_id(g);
        e_len  = len_t[g];
      end else if (m_awready) begin
        mv = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] g, input logic rdy,
                               input logic pop);
    @(posedge clk);
    #1;
    valid     = v;
    grant     = g;
    m_awready = rdy;
    ord_pop   = pop;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < REQ_NUM; i++) begin
      addr_t[i] = 32'h1000_0000 * (i + 1) + 32'h40;
      id_t[i]   = 4'(15 - i);
      len_t[i]  = 8'(i * 3 + 1);
    end
    rstn      = 1'b0;
    valid     = '0;
    grant     = '0;
    m_awready = 1'b0;
    ord_pop   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] reset idle");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
      chk("t1_m_awvalid", 64'(m_awvalid), 64'd0);
      chk("t1_arb_en",    64'(arb_en),    64'd0);
      chk("t1_ord_vld",   64'(ord_vld),   64'd0);
    end

    $display("[TB] single grant master 2");
    applyStimulus(8'h04, 8'h04, 1'b1, 1'b0);
    chk("t2_s_awready", 64'(s_awready), 64'h04);
    chk("t2_arb_en",    64'(arb_en),    64'd1);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    chk("t2_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("t2_m_awaddr",  64'(m_awaddr),  64'h3000_0040);
    chk("t2_m_awlen",   64'(m_awlen),   64'd7);
    chk("t2_ord_idx",   64'(ord_idx),   64'd2);
    chk("t2_arb_en_off", 64'(arb_en),   64'd0);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);

    $display("[TB] slave stall");
    applyStimulus(8'h20, 8'h20, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
      chk("t3_s_awready", 64'(s_awready), 64'h00);
      chk("t3_arb_en",    64'(arb_en),    64'd0);
      chk("t3_m_awvalid", 64'(m_awvalid), 64'd1);
      chk("t3_m_awaddr",  64'(m_awaddr),  64'h6000_0040);
    end
    applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
    chk("t3_b2b_ready", 64'(s_awready), 64'h01);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    chk("t3_reload_addr", 64'(m_awaddr), 64'h1000_0040);
    chk("t3_head5",       64'(ord_idx),  64'd5);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    chk("t3_drained", 64'(ord_vld), 64'd0);

    $display("[TB] streaming all masters");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(8'hFF, 8'(8'h01 << (k % 8)), 1'b1, 1'b1);
      chk("t4_arb_en", 64'(arb_en), 64'd1);
      if (k > 0) begin
        chk("t4_ord_idx",  64'(ord_idx),  64'((k - 1) % 8));
        chk("t4_m_awaddr", 64'(m_awaddr), 64'(32'h1000_0000 * (((k - 1) % 8) + 1) + 32'h40));
      end
    end
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    chk("t4_last_idx", 64'(ord_idx), 64'd7);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    chk("t4_empty", 64'(ord_vld), 64'd0);

    $display("[TB] order fifo full");
    applyStimulus(8'h02, 8'h02, 1'b1, 1'b0);
    applyStimulus(8'h08, 8'h08, 1'b1, 1'b0);
    applyStimulus(8'h10, 8'h10, 1'b1, 1'b0);
    applyStimulus(8'h40, 8'h40, 1'b1, 1'b0);
    chk("t5_fourth_ready", 64'(s_awready), 64'h40);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b1);
    chk("t5_blocked_ready", 64'(s_awready), 64'h00);
    chk("t5_blocked_en",    64'(arb_en),    64'd0);
    chk("t5_head",          64'(ord_idx),   64'd1);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0);
    chk("t5_retry_ready", 64'(s_awready), 64'h80);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
    chk("t5_m_awaddr", 64'(m_awaddr), 64'h8000_0040);
    chk("t5_head3",    64'(ord_idx),  64'd3);

    $display("[TB] reset mid-burst");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    chk("t6_pre_valid", 64'(m_awvalid), 64'd1);
    chk("t6_pre_head",  64'(ord_idx),   64'd4);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(m_awvalid), 64'd0);
    chk("t6_rst_ordv",  64'(ord_vld),   64'd0);
    chk("t6_rst_idx",   64'(ord_idx),   64'd0);
    chk("t6_rst_addr",  64'(m_awaddr),  64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    chk("t6_no_replay", 64'(m_awvalid), 64'd0);
    chk("t6_post_ordv", 64'(ord_vld),   64'd0);
    applyStimulus(8'h04, 8'h04, 1'b1, 1'b0);
    chk("t6_alive_en", 64'(arb_en), 64'd1);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    chk("t6_alive_idx", 64'(ord_idx), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
